// File: rtl/hash_digest_reader_pkg.sv
// Shared definitions for the SHA-256 digest read path: FSM encoding, word
// geometry and the SHA-256 initial hash values used by the H0..H7 bank.
package hash_digest_reader_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int DIGEST_W  = WORD_W * NUM_WORDS;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMP    = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [WORD_W-1:0] SHA256_IV [NUM_WORDS] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // SHA-256 words are big-endian; Bitcoin reads the digest as little-endian.
    function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/hash_digest_reader_cmp.sv
// One-word compare: byte-swap a hash word into its integer value and
// classify it against the matching target word.
module hash_word_cmp
    import hash_digest_reader_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] target_word,
    output logic              lt,
    output logic              eq,
    output logic              gt
);

    logic [WORD_W-1:0] value;

    assign value = bswap32(word);
    assign lt    = (value <  target_word);
    assign eq    = (value == target_word);
    assign gt    = (value >  target_word);

endmodule

// File: rtl/hash_digest_reader.sv
// Captures the final digest and nonce, compares it against the target most
// significant word first, then streams the digest out H0..H7.
module hash_digest_reader
    import hash_digest_reader_pkg::*;
#(
    parameter bit STREAM_ALL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                digest_valid,
    input  logic [DIGEST_W-1:0] digest_in,
    input  logic [WORD_W-1:0]   nonce_in,
    input  logic [DIGEST_W-1:0] target,
    output logic                busy,
    output logic                result_valid,
    output logic                hit,
    output logic [WORD_W-1:0]   hit_nonce,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_last,
    output logic                overrun
);

    state_t              state;
    state_t              state_nxt;
    logic [DIGEST_W-1:0] digest_q;
    logic [DIGEST_W-1:0] target_q;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_inc;
    logic [WORD_W-1:0]   cur_word;
    logic [WORD_W-1:0]   cur_target;
    logic                w_lt, w_eq, w_gt;
    logic                cmp_done, cmp_hit, go_stream, beat, last_beat;

    assign cur_word   = digest_q[int'(idx) * WORD_W +: WORD_W];
    assign cur_target = target_q[int'(idx) * WORD_W +: WORD_W];
    assign idx_inc    = idx + 1'b1;

    hash_word_cmp u_cmp (
        .word        (cur_word),
        .target_word (cur_target),
        .lt          (w_lt),
        .eq          (w_eq),
        .gt          (w_gt)
    );

    // Equality on the last (least significant) word still counts as a hit.
    assign cmp_done  = (state == CMP) && (w_lt || w_gt || (w_eq && idx == '0));
    assign cmp_hit   = w_lt || (w_eq && idx == '0);
    assign go_stream = cmp_hit || STREAM_ALL;
    assign beat      = (state == STREAM) && out_valid && out_ready;
    assign last_beat = beat && out_last;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (digest_valid) state_nxt = CMP;
            CMP:     if (cmp_done)     state_nxt = go_stream ? STREAM : IDLE;
            STREAM:  if (last_beat)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digest_q     <= '0;
            target_q     <= '0;
            hit_nonce    <= '0;
            idx          <= '0;
            result_valid <= 1'b0;
            hit          <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (digest_valid && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (digest_valid) begin
                        digest_q  <= digest_in;
                        target_q  <= target;
                        hit_nonce <= nonce_in;
                        idx       <= IDX_W'(NUM_WORDS - 1);
                    end
                end
                CMP: begin
                    if (cmp_done) begin
                        result_valid <= 1'b1;
                        hit          <= cmp_hit;
                        idx          <= '0;
                        if (go_stream) begin
                            out_valid <= 1'b1;
                            out_data  <= digest_q[WORD_W-1:0];
                            out_last  <= 1'b0;
                        end
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                STREAM: begin
                    // Beat registers only advance on a handshake, so they hold under backpressure.
                    if (beat) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            idx       <= '0;
                        end else begin
                            idx      <= idx_inc;
                            out_data <= digest_q[int'(idx_inc) * WORD_W +: WORD_W];
                            out_last <= (idx_inc == IDX_W'(NUM_WORDS - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_digest_reader.sv
// Directed bench for hash_digest_reader: compare latency/hit, stream order,
// backpressure, overrun and mid-stream reset, checked with immediate asserts.
module tb_hash_digest_reader;

    localparam int NW = 8;

    logic         clk;
    logic         rst_n;
    logic         digest_valid;
    logic [255:0] digest_in;
    logic [31:0]  nonce_in;
    logic [255:0] target;
    logic         busy;
    logic         result_valid;
    logic         hit;
    logic [31:0]  hit_nonce;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    hash_digest_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digest_valid (digest_valid),
        .digest_in    (digest_in),
        .nonce_in     (nonce_in),
        .target       (target),
        .busy         (busy),
        .result_valid (result_valid),
        .hit          (hit),
        .hit_nonce    (hit_nonce),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .overrun      (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [255:0] d, input logic [31:0] n, input logic [255:0] t);
        digest_in    = d;
        nonce_in     = n;
        target       = t;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
    endtask

    // Count cycles from the digest_valid cycle (1 = first CMP cycle) until result_valid.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!result_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic push_words(input logic [255:0] d);
        for (int i = 0; i < NW; i++) exp_q.push_back(d[32*i +: 32]);
    endtask

    task automatic collect(input int stall_beat, input int n_beats);
        int beats = 0;
        int stall = 0;
        int guard = 0;
        while (beats < n_beats && guard < 200) begin
            guard++;
            out_ready = 1'b1;
            if (beats == stall_beat && stall < 3) begin
                out_ready = 1'b0;
                stall++;
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", out_data, exp_q[0]);
            end
            if (out_valid && out_ready) begin
                check("beat_data", out_data, exp_q.pop_front());
                check("beat_last", 32'(out_last), 32'(beats == NW - 1));
                beats++;
            end
            tick();
        end
        out_ready = 1'b0;
        check("beat_count", 32'(beats), 32'(n_beats));
    endtask

    logic [255:0] d_eq, t_eq, t_near, d_a, t_a, t_diff1;
    int lat;

    initial begin
        d_eq    = {32'h00000000, 32'hFFFF0000, 32'h78563412, 32'hF0DEBC9A,
                   32'hEFBEADDE, 32'hBEBAFECA, 32'h0DF0AD0B, 32'hDF9B5713};
        t_eq    = {32'h00000000, 32'h0000FFFF, 32'h12345678, 32'h9ABCDEF0,
                   32'hDEADBEEF, 32'hCAFEBABE, 32'h0BADF00D, 32'h13579BDF};
        t_near  = {t_eq[255:32], 32'h13579BDE};
        d_a     = {32'h00000001, 32'hA0000006, 32'hA0000005, 32'hA0000004,
                   32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
        t_a     = {32'h02000000, 224'h0};
        t_diff1 = {32'h00000000, 32'hFFFF0000, 192'h0};

        rst_n = 1'b0; digest_valid = 1'b0; out_ready = 1'b0;
        digest_in = '0; nonce_in = '0; target = '0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_hit_nonce", hit_nonce, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        tick();

        // All-zero digest against an all-ones target: every word is less -> hit on top word.
        // Zero digest vs all-ones target decides at H7 (0 < FFFFFFFF).
        send('0, 32'h11111111, '1);
        wait_result(lat);
        check("zero_latency", 32'(lat), 32'd2);
        check("zero_hit", 32'(hit), 32'd1);
        push_words('0);
        collect(-1, NW);
        check("zero_idle", 32'(busy), 32'd0);

        // All-words-equal path: zero digest vs zero target -> equality hit after 9 cycles.
        send('0, 32'h22222222, '0);
        wait_result(lat);
        check("alleq_latency", 32'(lat), 32'd9);
        check("alleq_hit", 32'(hit), 32'd1);
        push_words('0);
        collect(-1, NW);

        // Early miss against the difficulty-1 target.
        send({32'h00000001, 224'h0}, 32'h33333333, t_diff1);
        wait_result(lat);
        check("miss_latency", 32'(lat), 32'd2);
        check("miss_hit", 32'(hit), 32'd0);
        tick();
        check("miss_busy", 32'(busy), 32'd0);
        check("miss_no_stream", 32'(out_valid), 32'd0);
        check("miss_pulse", 32'(result_valid), 32'd0);

        // Exact equality with distinct words, streamed under backpressure on H3.
        send(d_eq, 32'h1DAC2B7C, t_eq);
        wait_result(lat);
        check("eq_latency", 32'(lat), 32'd9);
        check("eq_hit", 32'(hit), 32'd1);
        check("eq_nonce", hit_nonce, 32'h1DAC2B7C);
        push_words(d_eq);
        collect(3, NW);
        check("eq_idle", 32'(busy), 32'd0);

        // One below equality on the last word: miss decided at the last compare.
        send(d_eq, 32'h44444444, t_near);
        wait_result(lat);
        check("near_latency", 32'(lat), 32'd9);
        check("near_hit", 32'(hit), 32'd0);
        tick();
        check("near_busy", 32'(busy), 32'd0);

        // Overrun: second digest arrives while streaming; stream stays on the first one.
        send(d_a, 32'hAAAA0001, t_a);
        wait_result(lat);
        check("ovr_latency", 32'(lat), 32'd2);
        check("ovr_hit", 32'(hit), 32'd1);
        send('1, 32'hBBBB0002, '1);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_nonce_kept", hit_nonce, 32'hAAAA0001);
        push_words(d_a);
        collect(-1, NW);
        tick(); tick();
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_idle", 32'(busy), 32'd0);

        // Reset after two beats aborts the stream; a fresh capture restarts at H0.
        send(d_a, 32'hCCCC0003, t_a);
        wait_result(lat);
        check("abort_hit", 32'(hit), 32'd1);
        push_words(d_a);
        collect(-1, 2);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_data", out_data, 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        check("abort_nonce", hit_nonce, 32'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        send(d_eq, 32'hDDDD0004, t_eq);
        wait_result(lat);
        check("fresh_latency", 32'(lat), 32'd9);
        check("fresh_nonce", hit_nonce, 32'hDDDD0004);
        push_words(d_eq);
        collect(-1, NW);
        check("fresh_overrun", 32'(overrun), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
